// File: rtl/mips_memory_access_unit_pkg.sv
// Mips_Memory_Access_Types: size codes, FSM states and lane geometry helpers shared by the load/store unit.
package Mips_Memory_Access_Types;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DWORD} size_t;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  function automatic int lanes(input int data_width);
    return data_width / 8;
  endfunction
  function automatic int off_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction
endpackage

// File: rtl/mips_memory_access_unit_if.sv
// mips_memory_access_unit_if: request, memory-beat and response signals of the load/store unit.
interface mips_memory_access_unit_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 32);
  logic req_valid, req_ready, req_write, req_unsigned;
  logic [1:0] req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic mem_valid, mem_ready, mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_byteEnable;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic resp_valid, resp_error, busy;
  logic [DATA_WIDTH-1:0] resp_data;
  modport slave (
    input req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, mem_valid, mem_write, mem_addr, mem_byteEnable, mem_wdata, resp_valid, resp_data, resp_error, busy
  );
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_ready, mem_rdata,
    input req_ready, mem_valid, mem_write, mem_addr, mem_byteEnable, mem_wdata, resp_valid, resp_data, resp_error, busy
  );
endinterface

// File: rtl/mips_memory_access_unit_extend.sv
// mips_memory_access_extend: aligns the two-beat read window by byte offset, truncates to access size, sign/zero-extends.
module mips_memory_access_extend import Mips_Memory_Access_Types::*; #(parameter int DATA_WIDTH = 32) (
  input  logic [2*DATA_WIDTH-1:0]          data,
  input  logic [off_width(DATA_WIDTH)-1:0] offset,
  input  logic [1:0]                       size,
  input  logic                             is_unsigned,
  output logic [DATA_WIDTH-1:0]            result
);
  localparam int MSB_W = $clog2(DATA_WIDTH);
  logic [2*DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] low, keep;
  logic [MSB_W-1:0] msb;
  logic sign;
  always_comb begin
    shifted = data >> {offset, 3'b000};
    low = shifted[DATA_WIDTH-1:0];
    keep = (DATA_WIDTH'(1) << (8 << size)) - DATA_WIDTH'(1);
    msb = MSB_W'((8 << size) - 1);
    sign = !is_unsigned && low[msb];
    result = (low & keep) | (sign ? ~keep : '0);
  end
endmodule

// File: rtl/mips_memory_access_unit.sv
// mips_memory_access_unit: load/store unit with valid/ready memory beats and extended load response.
// Define MIPS_MEMORY_ACCESS_UNALIGNED_EN to allow misaligned accesses (split into two beats when crossing a word).
module mips_memory_access_unit import Mips_Memory_Access_Types::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic clock,
  input logic reset,
  mips_memory_access_unit_if.slave bus
);
  localparam int LANES = lanes(DATA_WIDTH);
  localparam int OFF_W = off_width(DATA_WIDTH);
  state_t state, state_n;
  logic wr, uns, err, split, err_c;
  logic [1:0] size;
  logic [OFF_W-1:0] off, off_c;
  logic [ADDR_WIDTH-1:0] base;
  logic [2*LANES-1:0] mask, mask_c;
  logic [2*DATA_WIDTH-1:0] wdata, rdata;
  logic [DATA_WIDTH-1:0] ext;
  always_comb begin
    off_c = bus.req_addr[OFF_W-1:0];
    mask_c = (((2*LANES)'(1) << (1 << bus.req_size)) - (2*LANES)'(1)) << off_c;
`ifdef MIPS_MEMORY_ACCESS_UNALIGNED_EN
    err_c = (1 << bus.req_size) > LANES;
`else
    err_c = ((1 << bus.req_size) > LANES) || ((off_c & OFF_W'((1 << bus.req_size) - 1)) != '0);
`endif
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (bus.req_valid) state_n = err_c ? RESP : BEAT0;
      BEAT0: if (bus.mem_ready) state_n = split ? BEAT1 : RESP;
      BEAT1: if (bus.mem_ready) state_n = RESP;
      RESP:  state_n = IDLE;
    endcase
    bus.req_ready = state == IDLE;
    bus.busy = state != IDLE;
    bus.mem_valid = state == BEAT0 || state == BEAT1;
    bus.mem_write = bus.mem_valid && wr;
    bus.mem_addr = state == BEAT1 ? base + ADDR_WIDTH'(LANES) : state == BEAT0 ? base : '0;
    bus.mem_byteEnable = state == BEAT1 ? mask[2*LANES-1:LANES] : state == BEAT0 ? mask[LANES-1:0] : '0;
    bus.mem_wdata = state == BEAT1 ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : state == BEAT0 ? wdata[DATA_WIDTH-1:0] : '0;
    bus.resp_valid = state == RESP;
    bus.resp_error = state == RESP && err;
    bus.resp_data = (state == RESP && !wr && !err) ? ext : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // Request fields are frozen at acceptance so mem outputs stay stable across wait states.
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.req_valid) begin
      wr <= bus.req_write;
      size <= bus.req_size;
      uns <= bus.req_unsigned;
      off <= off_c;
      err <= err_c;
      base <= {bus.req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
      mask <= mask_c;
      split <= mask_c[2*LANES-1:LANES] != '0;
      wdata <= (2*DATA_WIDTH)'(bus.req_wdata) << {off_c, 3'b000};
    end
    if (state == BEAT0 && bus.mem_ready) rdata[DATA_WIDTH-1:0] <= bus.mem_rdata;
    if (state == BEAT1 && bus.mem_ready) rdata[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.mem_rdata;
  end
  mips_memory_access_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
    .data(rdata), .offset(off), .size(size), .is_unsigned(uns), .result(ext)
  );
endmodule

// File: tb/tb_mips_memory_access_unit.sv
// tb_mips_memory_access_unit: table vectors, corner sequences and random accesses against a byte-level model.
module tb_mips_memory_access_unit;
  localparam int DW = 32;
  localparam int AW = 32;
`ifdef MIPS_MEMORY_ACCESS_UNALIGNED_EN
  localparam bit UNAL = 1'b1;
`else
  localparam bit UNAL = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  mips_memory_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  mips_memory_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int passed = 0;
  logic [7:0] mem [logic [31:0]];
  int n_beats, lat;
  logic [31:0] b_addr [2];
  logic [3:0] b_be [2];
  logic [31:0] b_wd [2];
  logic b_wr [2];
  logic [31:0] r_data;
  logic r_err;

  typedef struct {
    logic w; logic [1:0] sz; logic u;
    logic [31:0] a, wd, rd;
    logic [3:0] be; logic [31:0] mwd, data; logic err; int lat;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  task automatic run(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input int waits);
    int wl;
    bit done;
    n_beats = 0; lat = 0; r_data = '0; r_err = 1'b0; done = 0; wl = waits;
    @(negedge clock);
    chk("idle_ready", 64'(bus.req_ready), 64'(1));
    chk("idle_no_resp", 64'(bus.resp_valid), 64'(0));
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_addr = a; bus.req_wdata = wd;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clock);
      bus.req_valid = 1'($urandom); bus.req_write = 1'($urandom); bus.req_size = 2'($urandom);
      bus.req_unsigned = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
      bus.mem_ready = 1'b0;
      chk("busy_flags", 64'({bus.busy, bus.req_ready}), 64'(2'b10));
      if (bus.mem_valid) begin
        if (wl == waits) begin
          if (n_beats < 2) begin
            b_addr[n_beats] = bus.mem_addr; b_be[n_beats] = bus.mem_byteEnable;
            b_wd[n_beats] = bus.mem_wdata; b_wr[n_beats] = bus.mem_write;
          end
        end else if (n_beats < 2) begin
          chk("hold_addr", 64'(bus.mem_addr), 64'(b_addr[n_beats]));
          chk("hold_be_wdata", 64'({bus.mem_byteEnable, bus.mem_wdata}), 64'({b_be[n_beats], b_wd[n_beats]}));
        end
        if (wl == 0) begin
          bus.mem_ready = 1'b1;
          for (int i = 0; i < 4; i++) bus.mem_rdata[8*i+:8] = rd_byte(bus.mem_addr + 32'(i));
          n_beats++;
          wl = waits;
        end else wl--;
      end
      if (bus.resp_valid) begin
        lat = c; r_data = bus.resp_data; r_err = bus.resp_error; done = 1;
        bus.req_valid = 1'b0;
      end
    end
    chk("resp_timeout", 64'(done), 64'(1));
    bus.req_valid = 1'b0;
  endtask

  task automatic check_model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                             input logic [31:0] wd, input int waits);
    int nb, eb, p;
    logic err;
    logic [31:0] w0, last, ba, v;
    logic [3:0] be [2];
    logic [31:0] wdx [2];
    nb = 1 << sz;
    err = (sz == 2'd3) || (!UNAL && ((a & 32'(nb - 1)) != 0));
    w0 = a & ~32'h3;
    last = a + 32'(nb - 1);
    eb = err ? 0 : (((last & ~32'h3) != w0) ? 2 : 1);
    be[0] = '0; be[1] = '0; wdx[0] = '0; wdx[1] = '0; v = '0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        ba = a + 32'(i);
        if ((ba & ~32'h3) == w0) be[0][ba[1:0]] = 1'b1;
        else be[1][ba[1:0]] = 1'b1;
      end
      if (!w) begin
        for (int i = 0; i < nb; i++) v[8*i+:8] = rd_byte(a + 32'(i));
        if (!u && v[8*nb-1]) for (int i = nb; i < 4; i++) v[8*i+:8] = 8'hFF;
      end
    end
    for (int j = 0; j < 4; j++) begin
      p = int'(a[1:0]) + j;
      if (p < 4) wdx[0][8*p+:8] = wd[8*j+:8];
      else wdx[1][8*(p-4)+:8] = wd[8*j+:8];
    end
    chk("m_err", 64'(r_err), 64'(err));
    chk("m_data", 64'(r_data), 64'(v));
    chk("m_latency", 64'(lat), 64'(err ? 1 : eb * (waits + 1) + 1));
    chk("m_beats", 64'(n_beats), 64'(eb));
    for (int k = 0; k < eb && k < n_beats; k++) begin
      chk("m_addr", 64'(b_addr[k]), 64'(w0 + 32'(4 * k)));
      chk("m_be", 64'(b_be[k]), 64'(be[k]));
      chk("m_wdata", 64'(b_wd[k]), 64'(wdx[k]));
      chk("m_write", 64'(b_wr[k]), 64'(w));
    end
  endtask

  initial begin
    logic w, u;
    logic [1:0] sz;
    logic [31:0] a, wd;
    int waits;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    tbl[0] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80FFFFFF, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0, 2};
    tbl[2] = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80FFFFFF, 4'h8, 32'h0,        32'h00000080, 1'b0, 2};
    tbl[3] = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234,     32'h0,        4'hC, 32'h12340000, 32'h0,        1'b0, 2};
    tbl[4] = '{1'b0, 2'd3, 1'b0, 32'h200, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1'b1, 1};
    tbl[5] = '{1'b0, 2'd1, 1'b1, 32'h202, 32'h0,        32'h80010000, 4'hC, 32'h0,        32'h00008001, 1'b0, 2};
    tbl[6] = '{1'b0, 2'd1, 1'b0, 32'h202, 32'h0,        32'h80010000, 4'hC, 32'h0,        32'hFFFF8001, 1'b0, 2};
    tbl[7] = '{1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB, 32'h0,        4'h2, 32'h0000AB00, 32'h0,        1'b0, 2};
    tbl[8] = '{1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0,        4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 2};
    tbl[9] = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        32'h12347FFF, 4'h3, 32'h0,        32'h00007FFF, 1'b0, 2};
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_outputs", 64'({bus.mem_valid, bus.resp_valid, bus.resp_error, bus.busy}), 64'(0));
    chk("rst_data", 64'({bus.resp_data, bus.mem_addr}), 64'(0));
    chk("rst_wdata_be", 64'({bus.mem_wdata, bus.mem_byteEnable}), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", 64'(bus.req_ready), 64'(1));

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 4; i++) mem[(tbl[t].a & ~32'h3) + 32'(i)] = tbl[t].rd[8*i+:8];
      run(tbl[t].w, tbl[t].sz, tbl[t].u, tbl[t].a, tbl[t].wd, 0);
      chk($sformatf("tbl%0d_err", t), 64'(r_err), 64'(tbl[t].err));
      chk($sformatf("tbl%0d_data", t), 64'(r_data), 64'(tbl[t].data));
      chk($sformatf("tbl%0d_lat", t), 64'(lat), 64'(tbl[t].lat));
      chk($sformatf("tbl%0d_beats", t), 64'(n_beats), 64'(tbl[t].err ? 0 : 1));
      if (n_beats > 0) begin
        chk($sformatf("tbl%0d_be", t), 64'(b_be[0]), 64'(tbl[t].be));
        chk($sformatf("tbl%0d_mwdata", t), 64'(b_wd[0]), 64'(tbl[t].mwd));
        chk($sformatf("tbl%0d_addr", t), 64'(b_addr[0]), 64'(tbl[t].a & ~32'h3));
      end
    end

    run(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 0);
`ifdef MIPS_MEMORY_ACCESS_UNALIGNED_EN
    chk("split_beats", 64'(n_beats), 64'(2));
    chk("split_beat0", 64'({b_addr[0], b_be[0]}), 64'({32'h0FC, 4'hC}));
    chk("split_beat1", 64'({b_addr[1], b_be[1]}), 64'({32'h100, 4'h3}));
    chk("split_lat", 64'(lat), 64'(3));
`else
    chk("misalign_err", 64'(r_err), 64'(1));
    chk("misalign_lat", 64'(lat), 64'(1));
    chk("misalign_no_beat", 64'(n_beats), 64'(0));
`endif
    check_model(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 0);

    run(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 1);
`ifdef MIPS_MEMORY_ACCESS_UNALIGNED_EN
    chk("wrap_beat0", 64'(b_addr[0]), 64'(32'hFFFFFFFC));
    chk("wrap_beat1", 64'(b_addr[1]), 64'(32'h0));
`else
    chk("wrap_err", 64'(r_err), 64'(1));
`endif
    check_model(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 1);

    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h100;
    @(negedge clock);
    bus.req_valid = 1'b0; bus.mem_ready = 1'b0;
    chk("stall_valid", 64'(bus.mem_valid), 64'(1));
    repeat (4) @(negedge clock);
    chk("stall_hold", 64'({bus.mem_valid, bus.mem_addr}), 64'({1'b1, 32'h100}));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_idle", 64'({bus.mem_valid, bus.busy, bus.req_ready, bus.resp_valid}), 64'(4'b0010));
    repeat (3) begin
      @(negedge clock);
      chk("midrst_no_resp", 64'(bus.resp_valid), 64'(0));
    end
    run(1'b0, 2'd1, 1'b0, 32'h0000_0346, 32'h0, 0);
    check_model(1'b0, 2'd1, 1'b0, 32'h0000_0346, 32'h0, 0);

    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom); u = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = $urandom; wd = $urandom; waits = $urandom_range(0, 2);
      if (n % 3 == 0) a = a & ~32'((1 << sz) - 1);
      if (n % 10 == 1) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      run(w, sz, u, a, wd, waits);
      check_model(w, sz, u, a, wd, waits);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
